// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: Difference = A - B, one bit per clock, LSB first.
// Latency: Start accepted at edge k -> Done_Out high after edge k+WIDTH; one op per WIDTH+2 cycles.
// Backpressure: none; Start_In is only sampled in IDLE and is dropped (not queued) while busy.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             Clock_In,
    input  logic             Reset_In,
    input  logic             Start_In,
    input  logic [WIDTH-1:0] Data_A_In,
    input  logic [WIDTH-1:0] Data_B_In,
    output logic             Busy_Out,
    output logic             Done_Out,
    output logic [WIDTH-1:0] Difference_Out,
    output logic             Borrow_Out,
    output logic             Overflow_Out
);

    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_next;

    logic [WIDTH-1:0]   r_a;        // minuend, shifted right each SHIFT cycle
    logic [WIDTH-1:0]   r_b;        // subtrahend, shifted right each SHIFT cycle
    logic [WIDTH-1:0]   r_res;      // partial result, filled from the MSB side
    logic               r_br;       // borrow carried between bit positions
    logic [CNT_W-1:0]   r_cnt;      // index of the bit being processed
    logic               r_a_msb;    // operand sign bits kept for the overflow test
    logic               r_b_msb;

    logic [WIDTH-1:0]   r_diff;
    logic               r_borrow;
    logic               r_ovf;

    logic               w_d;
    logic               w_br_next;
    logic               w_last;
    logic [WIDTH-1:0]   w_result;

    // Full-subtractor cell on the current LSBs plus the stored borrow.
    assign w_d       = r_a[0] ^ r_b[0] ^ r_br;
    assign w_br_next = (~r_a[0] & r_b[0]) | (~(r_a[0] ^ r_b[0]) & r_br);
    assign w_last    = (r_cnt == CNT_W'(WIDTH - 1));
    // Result register after this cycle's shift; complete when w_last is set.
    assign w_result  = {w_d, r_res[WIDTH-1:1]};

    // State register.
    always_ff @(posedge Clock_In) begin
        if (Reset_In) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: accept in IDLE, run WIDTH shift cycles, one DONE cycle.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (Start_In) w_state_next = S_SHIFT;
            S_SHIFT: if (w_last)   w_state_next = S_DONE;
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Datapath: operand load, serial shift, and result capture on the last bit.
    always_ff @(posedge Clock_In) begin
        if (Reset_In) begin
            r_a      <= '0;
            r_b      <= '0;
            r_res    <= '0;
            r_br     <= 1'b0;
            r_cnt    <= '0;
            r_a_msb  <= 1'b0;
            r_b_msb  <= 1'b0;
            r_diff   <= '0;
            r_borrow <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (Start_In) begin
                        r_a     <= Data_A_In;
                        r_b     <= Data_B_In;
                        r_res   <= '0;
                        r_br    <= 1'b0;
                        r_cnt   <= '0;
                        r_a_msb <= Data_A_In[WIDTH-1];
                        r_b_msb <= Data_B_In[WIDTH-1];
                    end
                end
                S_SHIFT: begin
                    r_a   <= r_a >> 1;
                    r_b   <= r_b >> 1;
                    r_res <= w_result;
                    r_br  <= w_br_next;
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (w_last) begin
                        r_diff   <= w_result;
                        r_borrow <= w_br_next;
                        // Signed overflow only when signs differ and the result sign leaves A's sign.
                        r_ovf    <= (r_a_msb != r_b_msb) & (w_d != r_a_msb);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign Busy_Out       = (r_state == S_SHIFT);
    assign Done_Out       = (r_state == S_DONE);
    assign Difference_Out = r_diff;
    assign Borrow_Out     = r_borrow;
    assign Overflow_Out   = r_ovf;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor at WIDTH=8 and WIDTH=13.
// Directed vector table, hand-written corner sequences, then randomised operands vs a reference model.
// Inputs driven and outputs sampled on the falling clock edge.
module tb_serial_subtractor;

    logic        clk;
    logic        rst;
    logic        start_tb;
    logic [12:0] a_tb;
    logic [12:0] b_tb;
    int          sel;

    logic        busy8, done8, bor8, ovf8;
    logic [7:0]  diff8;
    logic        busy13, done13, bor13, ovf13;
    logic [12:0] diff13;

    logic        m_busy, m_done, m_bor, m_ovf;
    logic [12:0] m_diff;

    int checks = 0;
    int errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(8)) u_dut8 (
        .Clock_In       (clk),
        .Reset_In       (rst),
        .Start_In       (start_tb && (sel == 8)),
        .Data_A_In      (a_tb[7:0]),
        .Data_B_In      (b_tb[7:0]),
        .Busy_Out       (busy8),
        .Done_Out       (done8),
        .Difference_Out (diff8),
        .Borrow_Out     (bor8),
        .Overflow_Out   (ovf8)
    );

    serial_subtractor #(.WIDTH(13)) u_dut13 (
        .Clock_In       (clk),
        .Reset_In       (rst),
        .Start_In       (start_tb && (sel == 13)),
        .Data_A_In      (a_tb),
        .Data_B_In      (b_tb),
        .Busy_Out       (busy13),
        .Done_Out       (done13),
        .Difference_Out (diff13),
        .Borrow_Out     (bor13),
        .Overflow_Out   (ovf13)
    );

    always_comb begin
        m_busy = busy8;
        m_done = done8;
        m_bor  = bor8;
        m_ovf  = ovf8;
        m_diff = {5'd0, diff8};
        if (sel == 13) begin
            m_busy = busy13;
            m_done = done13;
            m_bor  = bor13;
            m_ovf  = ovf13;
            m_diff = diff13;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic on unsigned and signed interpretations.
    task automatic ref_sub(input int w, input logic [12:0] a, input logic [12:0] b,
                           output logic [12:0] d, output logic bo, output logic ov);
        longint ua, ub, sa, sb, r, m;
        m  = (longint'(1) << w);
        ua = longint'(a);
        ub = longint'(b);
        d  = 13'((ua - ub + m) % m);
        bo = (ua < ub);
        sa = (ua >= m / 2) ? ua - m : ua;
        sb = (ub >= m / 2) ? ub - m : ub;
        r  = sa - sb;
        ov = (r >= m / 2) || (r < -(m / 2));
    endtask

    // Runs one operation; reports latency, busy cycles, output hold and single-pulse Done.
    task automatic run_op(input logic [12:0] a, input logic [12:0] b,
                          output logic [12:0] d, output logic bo, output logic ov,
                          output int lat, output int bc, output bit held, output bit pulse);
        logic [12:0] d0;
        int n;
        d0   = m_diff;
        held = 1'b1;
        bc   = 0;
        @(negedge clk);
        a_tb = a; b_tb = b; start_tb = 1'b1;
        @(negedge clk);
        start_tb = 1'b0;
        n = 1;
        while (!m_done && n < 40) begin
            if (m_busy) bc++;
            if (m_diff !== d0) held = 1'b0;
            @(negedge clk);
            n++;
        end
        lat = n - 1;
        d   = m_diff;
        bo  = m_bor;
        ov  = m_ovf;
        @(negedge clk);
        pulse = !m_done;
    endtask

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] d;
        logic       bo;
        logic       ov;
    } vec_t;

    vec_t vecs[7];

    initial begin
        logic [12:0] d, ed;
        logic bo, ov, ebo, eov;
        int lat, bc, n;
        bit held, pulse, seen;
        logic [12:0] mask;

        vecs[0] = '{8'h5A, 8'h3C, 8'h1E, 1'b0, 1'b0};
        vecs[1] = '{8'h00, 8'h01, 8'hFF, 1'b1, 1'b0};
        vecs[2] = '{8'h80, 8'h01, 8'h7F, 1'b0, 1'b1};
        vecs[3] = '{8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1};
        vecs[4] = '{8'hC3, 8'hC3, 8'h00, 1'b0, 1'b0};
        vecs[5] = '{8'h01, 8'h80, 8'h81, 1'b1, 1'b1};
        vecs[6] = '{8'h09, 8'h0A, 8'hFF, 1'b1, 1'b0};

        sel = 8; rst = 1'b1; start_tb = 1'b0; a_tb = '0; b_tb = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_busy", 32'(m_busy), 32'd0);
        chk("reset_done", 32'(m_done), 32'd0);
        chk("reset_diff", 32'(m_diff), 32'd0);
        chk("reset_borrow", 32'(m_bor), 32'd0);
        chk("reset_ovf", 32'(m_ovf), 32'd0);

        // Directed table.
        for (int i = 0; i < 7; i++) begin
            run_op({5'd0, vecs[i].a}, {5'd0, vecs[i].b}, d, bo, ov, lat, bc, held, pulse);
            chk($sformatf("vec%0d_diff", i), 32'(d), 32'(vecs[i].d));
            chk($sformatf("vec%0d_borrow", i), 32'(bo), 32'(vecs[i].bo));
            chk($sformatf("vec%0d_ovf", i), 32'(ov), 32'(vecs[i].ov));
            chk($sformatf("vec%0d_latency", i), 32'(lat), 32'd8);
            chk($sformatf("vec%0d_busy_cycles", i), 32'(bc), 32'd8);
            chk($sformatf("vec%0d_held_in_shift", i), 32'(held), 32'd1);
            chk($sformatf("vec%0d_done_single", i), 32'(pulse), 32'd1);
        end

        // Start during SHIFT is ignored; later operand changes have no effect.
        @(negedge clk);
        a_tb = 13'h10; b_tb = 13'h01; start_tb = 1'b1;
        @(negedge clk);
        start_tb = 1'b0;
        repeat (2) @(negedge clk);
        a_tb = 13'hFF; b_tb = 13'h00; start_tb = 1'b1;
        @(negedge clk);
        start_tb = 1'b0;
        n = 0;
        while (!m_done && n < 40) begin @(negedge clk); n++; end
        chk("ignored_start_diff", 32'(m_diff), 32'h0F);
        @(negedge clk);
        @(negedge clk);
        chk("ignored_start_no_rerun", 32'(m_busy), 32'd0);

        // Start held high: re-accepted on the IDLE edge following DONE.
        a_tb = 13'h20; b_tb = 13'h05; start_tb = 1'b1;
        n = 0;
        while (!m_done && n < 40) begin @(negedge clk); n++; end
        chk("held_start_diff1", 32'(m_diff), 32'h1B);
        a_tb = 13'h30;
        @(negedge clk);
        chk("held_start_idle_busy", 32'(m_busy), 32'd0);
        chk("held_start_idle_done", 32'(m_done), 32'd0);
        @(negedge clk);
        chk("held_start_restart", 32'(m_busy), 32'd1);
        start_tb = 1'b0;
        n = 0;
        while (!m_done && n < 40) begin @(negedge clk); n++; end
        chk("held_start_diff2", 32'(m_diff), 32'h2B);

        // Reset in SHIFT aborts the operation with no Done pulse.
        @(negedge clk);
        a_tb = 13'h33; b_tb = 13'h11; start_tb = 1'b1;
        @(negedge clk);
        start_tb = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midreset_busy", 32'(m_busy), 32'd0);
        chk("midreset_done", 32'(m_done), 32'd0);
        chk("midreset_diff", 32'(m_diff), 32'd0);
        chk("midreset_borrow", 32'(m_bor), 32'd0);
        chk("midreset_ovf", 32'(m_ovf), 32'd0);
        seen = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (m_done || m_busy) seen = 1'b1;
        end
        chk("midreset_no_done", 32'(seen), 32'd0);
        run_op(13'h09, 13'h0A, d, bo, ov, lat, bc, held, pulse);
        chk("post_reset_diff", 32'(d), 32'hFF);
        chk("post_reset_borrow", 32'(bo), 32'd1);

        // Randomised operands at both widths.
        foreach (vecs[0].a[k]) begin end
        for (int w = 8; w <= 13; w += 5) begin
            sel  = w;
            mask = 13'((1 << w) - 1);
            @(negedge clk);
            for (int i = 0; i < 1000; i++) begin
                logic [12:0] ra, rb;
                ra = 13'($urandom) & mask;
                rb = 13'($urandom) & mask;
                if (i % 50 == 0) rb = ra;
                ref_sub(w, ra, rb, ed, ebo, eov);
                run_op(ra, rb, d, bo, ov, lat, bc, held, pulse);
                chk($sformatf("rand_w%0d_diff a=%0h b=%0h", w, ra, rb), 32'(d), 32'(ed));
                chk($sformatf("rand_w%0d_borrow a=%0h b=%0h", w, ra, rb), 32'(bo), 32'(ebo));
                chk($sformatf("rand_w%0d_ovf a=%0h b=%0h", w, ra, rb), 32'(ov), 32'(eov));
                chk($sformatf("rand_w%0d_latency", w), 32'(lat), 32'(w));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
